// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the variable-depth delay line.
package delay_line_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // A select port is never narrower than one bit, even for degenerate depths.
  function automatic int sel_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned depth);
    return (sel > depth - 1) ? depth - 1 : sel;
  endfunction

endpackage

// File: rtl/delay_line_stage.sv
// One WIDTH-bit stage of the delay line: flush has priority over shift enable.
module delay_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/var_delay_line.sv
// Variable-depth delay line: DEPTH registered stages with a run-time tap select.
// Defining DELAY_LINE_VALID_EN adds a fill counter and the q_valid output.
module var_delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SEL_W = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q
`ifdef DELAY_LINE_VALID_EN
  ,
  output logic             q_valid
`endif
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [SEL_W-1:0] sel_eff;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] stage_in;
    if (k == 0) begin : g_head
      assign stage_in = d;
    end else begin : g_tail
      assign stage_in = stage_q[k-1];
    end

    delay_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en_i (en),
      .clr_i(clr),
      .d_i  (stage_in),
      .q_o  (stage_q[k])
    );
  end

  // Clamping keeps the mux index inside the stage array for non-power-of-2 depths.
  assign sel_eff = SEL_W'(clamp_sel(32'(sel), 32'(DEPTH)));
  assign q       = stage_q[sel_eff];

`ifdef DELAY_LINE_VALID_EN
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;

  always_comb begin
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (en && (fill_q != FILL_W'(DEPTH))) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign q_valid = (32'(fill_q) > 32'(sel_eff));
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: a DEPTH=4 instance plus a DEPTH=5 instance for clamping.
module tb_var_delay_line;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] d;
  logic [1:0] sel4;
  logic [2:0] sel5;
  logic [7:0] q4;
  logic [7:0] q5;
`ifdef DELAY_LINE_VALID_EN
  logic       q_valid4;
  logic       q_valid5;
`endif

  int checks   = 0;
  int failures = 0;

  var_delay_line #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .sel(sel4), .q(q4)
`ifdef DELAY_LINE_VALID_EN
    , .q_valid(q_valid4)
`endif
  );

  var_delay_line #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .sel(sel5), .q(q5)
`ifdef DELAY_LINE_VALID_EN
    , .q_valid(q_valid5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush();
    clr = 1'b1;
    en  = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (q4 !== 8'h00) begin failures++; $display("FAIL reset_q4 got=%0h exp=0", q4); end
    checks++;
    if (q5 !== 8'h00) begin failures++; $display("FAIL reset_q5 got=%0h exp=0", q5); end
    en = 1'b1;
    d  = 8'hAA;
    tick();
    tick();
    checks++;
    if (q4 !== 8'h00) begin failures++; $display("FAIL reset_hold_q4 got=%0h exp=0", q4); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b0) begin failures++; $display("FAIL reset_qvalid got=%0b exp=0", q_valid4); end
`endif
    rst_n = 1'b1;
    d     = 8'd5;
    sel4  = 2'd0;
    sel5  = 3'd0;
    tick();
    checks++;
    if (q4 !== 8'd5) begin failures++; $display("FAIL reset_first_q4 got=%0h exp=5", q4); end
    checks++;
    if (q5 !== 8'd5) begin failures++; $display("FAIL reset_first_q5 got=%0h exp=5", q5); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b1) begin failures++; $display("FAIL reset_first_qvalid got=%0b exp=1", q_valid4); end
`endif
  endtask

  task automatic test_ramp();
    logic [7:0] exp;
    do_flush();
    for (int i = 0; i < 16; i++) begin
      d    = 8'(i);
      sel4 = 2'(i / 4);
      tick();
      exp = (i >= i / 4) ? 8'(i - i / 4) : 8'd0;
      checks++;
      if (q4 !== exp) begin failures++; $display("FAIL ramp_q i=%0d got=%0h exp=%0h", i, q4, exp); end
`ifdef DELAY_LINE_VALID_EN
      checks++;
      if (q_valid4 !== 1'b1) begin failures++; $display("FAIL ramp_qvalid i=%0d got=%0b exp=1", i, q_valid4); end
`endif
    end
    d = 8'd0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      exp = (j < 4) ? 8'(12 + j) : 8'd0;
      checks++;
      if (q4 !== exp) begin failures++; $display("FAIL drain_q j=%0d got=%0h exp=%0h", j, q4, exp); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    do_flush();
    sel4 = 2'd2;
    for (int i = 0; i < 6; i++) begin
      d = 8'(i);
      tick();
      exp = (i >= 2) ? 8'(i - 2) : 8'd0;
      checks++;
      if (q4 !== exp) begin failures++; $display("FAIL stall_pre i=%0d got=%0h exp=%0h", i, q4, exp); end
    end
    en = 1'b0;
    d  = 8'd99;
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++;
      if (q4 !== 8'd3) begin failures++; $display("FAIL stall_hold s=%0d got=%0h exp=3", s, q4); end
    end
    en = 1'b1;
    for (int i = 6; i < 10; i++) begin
      d = 8'(i);
      tick();
      exp = 8'(i - 2);
      checks++;
      if (q4 !== exp) begin failures++; $display("FAIL stall_resume i=%0d got=%0h exp=%0h", i, q4, exp); end
    end
  endtask

  task automatic test_flush();
    sel4 = 2'd1;
    en   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      tick();
    end
    clr = 1'b1;
    d   = 8'd9;
    tick();
    clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      #1;
      checks++;
      if (q4 !== 8'd0) begin failures++; $display("FAIL flush_tap s=%0d got=%0h exp=0", s, q4); end
    end
    sel4 = 2'd1;
`ifdef DELAY_LINE_VALID_EN
    #1;
    checks++;
    if (q_valid4 !== 1'b0) begin failures++; $display("FAIL flush_qvalid got=%0b exp=0", q_valid4); end
`endif
    d = 8'd21;
    tick();
    checks++;
    if (q4 !== 8'd0) begin failures++; $display("FAIL flush_e1_q got=%0h exp=0", q4); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b0) begin failures++; $display("FAIL flush_e1_qvalid got=%0b exp=0", q_valid4); end
`endif
    en = 1'b0;
    d  = 8'd55;
    tick();
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b0) begin failures++; $display("FAIL flush_stall_qvalid got=%0b exp=0", q_valid4); end
`endif
    en = 1'b1;
    d  = 8'd22;
    tick();
    checks++;
    if (q4 !== 8'd21) begin failures++; $display("FAIL flush_e2_q got=%0h exp=21", q4); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b1) begin failures++; $display("FAIL flush_e2_qvalid got=%0b exp=1", q_valid4); end
`endif
  endtask

  task automatic test_clamp();
    logic [7:0] exp;
    do_flush();
    sel5 = 3'd7;
    for (int i = 0; i < 8; i++) begin
      d = 8'(i + 1);
      tick();
      exp = (i >= 4) ? 8'(i - 3) : 8'd0;
      checks++;
      if ((q5 !== exp) || ($isunknown(q5) !== 1'b0)) begin
        failures++; $display("FAIL clamp_q i=%0d got=%0h exp=%0h", i, q5, exp);
      end
`ifdef DELAY_LINE_VALID_EN
      checks++;
      if (q_valid5 !== (i >= 4)) begin failures++; $display("FAIL clamp_qvalid i=%0d got=%0b exp=%0b", i, q_valid5, (i >= 4)); end
`endif
    end
    for (int s = 4; s < 8; s++) begin
      sel5 = 3'(s);
      #1;
      checks++;
      if (q5 !== 8'd4) begin failures++; $display("FAIL clamp_sel s=%0d got=%0h exp=4", s, q5); end
    end
  endtask

  task automatic test_async_reset();
    en   = 1'b1;
    sel4 = 2'd0;
    d    = 8'h33;
    tick();
    tick();
    checks++;
    if (q4 !== 8'h33) begin failures++; $display("FAIL async_pre got=%0h exp=33", q4); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (q4 !== 8'h00) begin failures++; $display("FAIL async_q4 got=%0h exp=0", q4); end
    checks++;
    if (q5 !== 8'h00) begin failures++; $display("FAIL async_q5 got=%0h exp=0", q5); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b0) begin failures++; $display("FAIL async_qvalid got=%0b exp=0", q_valid4); end
`endif
    d    = 8'd7;
    sel4 = 2'd1;
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if (q4 !== 8'd0) begin failures++; $display("FAIL async_e1_q got=%0h exp=0", q4); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b0) begin failures++; $display("FAIL async_e1_qvalid got=%0b exp=0", q_valid4); end
`endif
    tick();
    checks++;
    if (q4 !== 8'd7) begin failures++; $display("FAIL async_e2_q got=%0h exp=7", q4); end
`ifdef DELAY_LINE_VALID_EN
    checks++;
    if (q_valid4 !== 1'b1) begin failures++; $display("FAIL async_e2_qvalid got=%0b exp=1", q_valid4); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    d     = 8'hAA;
    sel4  = 2'd0;
    sel5  = 3'd0;
    #3;
    test_reset();
    test_ramp();
    test_stall();
    test_flush();
    test_clamp();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
